// File: rtl/dekatron_pkg.sv
// Shared types and BCD helpers for the dekatron step sequencer.
package dekatron_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PH_A,
      PH_B,
      GAP,
      CLRP,
      DONE
   } state_t;

   localparam logic DIR_INC = 1'b0;
   localparam logic DIR_DEC = 1'b1;

   localparam int TICK_W = 16;

   typedef logic [3:0] bcd_t;

   typedef struct packed {
      logic carry;
      bcd_t digit;
   } bcd_step_t;

   function automatic bcd_step_t bcd_inc(input bcd_t d);
      bcd_step_t r;
      if (d >= 4'd9) begin
         r.carry = 1'b1;
         r.digit = 4'd0;
      end else begin
         r.carry = 1'b0;
         r.digit = d + 4'd1;
      end
      return r;
   endfunction

   function automatic bcd_step_t bcd_dec(input bcd_t d);
      bcd_step_t r;
      if (d == 4'd0) begin
         r.carry = 1'b1;
         r.digit = 4'd9;
      end else begin
         r.carry = 1'b0;
         r.digit = d - 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/dekatron_pulse_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module dekatron_pulse_timer
   import dekatron_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [TICK_W-1:0] load_val,
   output logic              tc
);

   logic [TICK_W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign tc = (count == '0);

endmodule

// File: rtl/dekatron_step_ctrl.sv
// Single-step sequencer for a chain of dekatron stages: two-phase guide
// pulses per digit, digit-by-digit carry/borrow ripple, BCD shadow value.
module dekatron_step_ctrl
   import dekatron_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int PULSE_TICKS = 2,
   parameter int GAP_TICKS   = 1
) (
   input  logic                  CLOCK,
   input  logic                  RST,
   input  logic                  REQ,
   input  logic                  DIR,
   input  logic                  CLR,
   output logic                  ACK,
   output logic                  BUSY,
   output logic [DIGITS-1:0]     GUIDE1,
   output logic [DIGITS-1:0]     GUIDE2,
   output logic                  CATH_RST,
   output logic [4*DIGITS-1:0]   VALUE,
   output logic                  ZERO,
   output logic                  OVF
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
   localparam logic [TICK_W-1:0] PULSE_LOAD = TICK_W'(PULSE_TICKS - 1);
   localparam logic [TICK_W-1:0] GAP_LOAD = TICK_W'(GAP_TICKS - 1);

   state_t                state, state_next;
   logic [IDX_W-1:0]      idx;
   logic                  dir_q;
   logic [4*DIGITS-1:0]   value;
   logic                  ovf;

   logic                  tmr_load;
   logic [TICK_W-1:0]     tmr_val;
   logic                  tmr_tc;
   logic                  start_step;
   logic                  do_update;
   logic                  do_clear;

   bcd_t                  cur_digit;
   bcd_step_t             step_res;
   logic [DIGITS-1:0]     guide_sel;
   logic                  phase_g1;
   logic                  phase_g2;

   dekatron_pulse_timer u_timer (
      .clk      (CLOCK),
      .rst      (RST),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tc       (tmr_tc)
   );

   assign cur_digit = value[4*idx +: 4];
   assign step_res  = (dir_q == DIR_INC) ? bcd_inc(cur_digit) : bcd_dec(cur_digit);

   always_ff @(posedge CLOCK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // REQ/ACK handshake: REQ and CLR are levels looked at only in IDLE (CLR wins);
   // ACK pulses for one cycle in DONE, after VALUE already shows the result.
   always_comb begin
      state_next = state;
      tmr_load   = 1'b0;
      tmr_val    = '0;
      start_step = 1'b0;
      do_update  = 1'b0;
      do_clear   = 1'b0;
      case (state)
         IDLE: begin
            if (CLR) begin
               state_next = CLRP;
               tmr_load   = 1'b1;
               tmr_val    = PULSE_LOAD;
            end else if (REQ) begin
               state_next = PH_A;
               start_step = 1'b1;
               tmr_load   = 1'b1;
               tmr_val    = PULSE_LOAD;
            end
         end
         PH_A: begin
            if (tmr_tc) begin
               state_next = PH_B;
               tmr_load   = 1'b1;
               tmr_val    = PULSE_LOAD;
            end
         end
         PH_B: begin
            if (tmr_tc) begin
               state_next = GAP;
               tmr_load   = 1'b1;
               tmr_val    = GAP_LOAD;
            end
         end
         GAP: begin
            if (tmr_tc) begin
               do_update = 1'b1;
               if (step_res.carry && (idx != LAST_IDX)) begin
                  state_next = PH_A;
                  tmr_load   = 1'b1;
                  tmr_val    = PULSE_LOAD;
               end else begin
                  state_next = DONE;
               end
            end
         end
         CLRP: begin
            if (tmr_tc) begin
               do_clear   = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLOCK or posedge RST) begin
      if (RST) begin
         idx   <= '0;
         dir_q <= DIR_INC;
         value <= '0;
         ovf   <= 1'b0;
      end else begin
         if (start_step) begin
            dir_q <= DIR;
            idx   <= '0;
            ovf   <= 1'b0;
         end
         if (do_update) begin
            value[4*idx +: 4] <= step_res.digit;
            if (step_res.carry) begin
               if (idx == LAST_IDX) begin
                  ovf <= 1'b1;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
         end
         if (do_clear) begin
            value <= '0;
            ovf   <= 1'b0;
         end
      end
   end

   // Increment fires guide-1 first, decrement guide-2 first, on the active digit.
   assign guide_sel = DIGITS'(1) << idx;
   assign phase_g1  = ((state == PH_A) && (dir_q == DIR_INC)) ||
                      ((state == PH_B) && (dir_q == DIR_DEC));
   assign phase_g2  = ((state == PH_A) && (dir_q == DIR_DEC)) ||
                      ((state == PH_B) && (dir_q == DIR_INC));

   assign GUIDE1   = phase_g1 ? guide_sel : '0;
   assign GUIDE2   = phase_g2 ? guide_sel : '0;
   assign ACK      = (state == DONE);
   assign BUSY     = (state != IDLE);
   assign CATH_RST = (state == CLRP);
   assign VALUE    = value;
   assign ZERO     = (value == '0);
   assign OVF      = ovf;

endmodule

// File: tb/tb_dekatron_step_ctrl.sv
// Self-checking bench for dekatron_step_ctrl: per-cycle guide/ACK timing checks
// plus a scoreboard of expected {OVF, VALUE} popped on every ACK.
module tb_dekatron_step_ctrl;

   localparam int DIGITS = 4;
   localparam int PULSE  = 2;
   localparam int GAPT   = 1;
   localparam int PER    = 2*PULSE + GAPT;
   localparam int MAXV   = 10000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic req = 1'b0;
   logic dir = 1'b0;
   logic clr = 1'b0;
   logic ack, busy, cath_rst, zero, ovf;
   logic [DIGITS-1:0]   guide1, guide2;
   logic [4*DIGITS-1:0] value;

   logic [4*DIGITS:0] exp_q[$];
   logic [4*DIGITS:0] sb_e;
   int checks = 0;
   int errors = 0;
   int model_value = 0;

   dekatron_step_ctrl #(
      .DIGITS      (DIGITS),
      .PULSE_TICKS (PULSE),
      .GAP_TICKS   (GAPT)
   ) dut (
      .CLOCK    (clk),
      .RST      (rst),
      .REQ      (req),
      .DIR      (dir),
      .CLR      (clr),
      .ACK      (ack),
      .BUSY     (busy),
      .GUIDE1   (guide1),
      .GUIDE2   (guide2),
      .CATH_RST (cath_rst),
      .VALUE    (value),
      .ZERO     (zero),
      .OVF      (ovf)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
      logic [4*DIGITS-1:0] r;
      int x;
      r = '0;
      x = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic int ripple(input int v, input logic d);
      int n;
      int x;
      n = 1;
      x = v;
      for (int i = 0; i < DIGITS-1; i++) begin
         if ((d == 1'b0) ? (x % 10 == 9) : (x % 10 == 0)) begin
            n++;
            x = x / 10;
         end else begin
            break;
         end
      end
      return n;
   endfunction

   // Advance the decimal model one step and queue the expected result.
   task automatic push_step(input logic d);
      logic wrap;
      if (d == 1'b0) begin
         wrap = (model_value == MAXV-1);
         model_value = (model_value + 1) % MAXV;
      end else begin
         wrap = (model_value == 0);
         model_value = (model_value + MAXV - 1) % MAXV;
      end
      exp_q.push_back({wrap, to_bcd(model_value)});
   endtask

   task automatic push_clear();
      model_value = 0;
      exp_q.push_back({1'b0, to_bcd(0)});
   endtask

   // scoreboard
   always @(negedge clk) begin
      if (!rst && ack) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_ack", 32'd1, 32'd0);
         end else begin
            sb_e = exp_q.pop_front();
            check("sb_value", 32'(value), 32'(sb_e[4*DIGITS-1:0]));
            check("sb_ovf", 32'(ovf), 32'(sb_e[4*DIGITS]));
            check("sb_zero", 32'(zero), 32'(sb_e[4*DIGITS-1:0] == '0));
         end
      end
   end

   // One step with full per-cycle guide / ACK timing checks; called at a negedge in IDLE.
   task automatic run_step(input logic d);
      int n;
      int exp_ack;
      int k;
      int ph;
      logic [DIGITS-1:0] ea, eb;
      n = ripple(model_value, d);
      exp_ack = 1 + PER*n;
      push_step(d);
      req = 1'b1;
      dir = d;
      for (int t = 1; t <= exp_ack; t++) begin
         @(negedge clk);
         if (t == 1) begin
            req = 1'b0;
            dir = ~d;
         end
         k = (t - 1) / PER;
         ph = (t - 1) % PER;
         ea = '0;
         eb = '0;
         if (k < n) begin
            if (ph < PULSE) ea = DIGITS'(1) << k;
            else if (ph < 2*PULSE) eb = DIGITS'(1) << k;
         end
         check("step_guide1", 32'(guide1), 32'((d == 1'b0) ? ea : eb));
         check("step_guide2", 32'(guide2), 32'((d == 1'b0) ? eb : ea));
         check("step_busy", 32'(busy), 32'd1);
         check("step_ack", 32'(ack), 32'(t == exp_ack));
      end
      @(negedge clk);
      check("step_idle_busy", 32'(busy), 32'd0);
   endtask

   task automatic run_clr(input logic with_req);
      if (with_req) begin
         req = 1'b1;
         dir = 1'($urandom_range(0, 1));
      end
      clr = 1'b1;
      push_clear();
      for (int t = 1; t <= PULSE + 1; t++) begin
         @(negedge clk);
         if (t == 1) begin
            clr = 1'b0;
            req = 1'b0;
         end
         check("clr_cath_rst", 32'(cath_rst), 32'(t <= PULSE));
         check("clr_ack", 32'(ack), 32'(t == PULSE + 1));
         check("clr_guides", 32'(guide1 | guide2), 32'd0);
      end
      @(negedge clk);
      check("clr_idle_busy", 32'(busy), 32'd0);
   endtask

   task automatic run_b2b();
      int acks;
      int at[3];
      acks = 0;
      for (int i = 0; i < 3; i++) push_step(1'b0);
      req = 1'b1;
      dir = 1'b0;
      for (int t = 1; t <= 30; t++) begin
         @(negedge clk);
         if (ack) begin
            if (acks < 3) at[acks] = t;
            acks++;
            if (acks == 3) req = 1'b0;
         end
         if (t == 2) req = 1'b0;
         if (t == 3) clr = 1'b1;
         if (t == 4) begin
            req = 1'b1;
            clr = 1'b0;
         end
      end
      check("b2b_ack_count", 32'(acks), 32'd3);
      if (acks == 3) begin
         check("b2b_first_ack", 32'(at[0]), 32'(1 + PER));
         check("b2b_spacing1", 32'(at[1] - at[0]), 32'(PER + 2));
         check("b2b_spacing2", 32'(at[2] - at[1]), 32'(PER + 2));
      end
      check("b2b_idle_busy", 32'(busy), 32'd0);
   endtask

   // Reset lands while digit 1 is in its second guide phase of a 0000 -1 step.
   task automatic run_reset_mid();
      req = 1'b1;
      dir = 1'b1;
      for (int t = 1; t <= PER + PULSE + 1; t++) begin
         @(negedge clk);
         if (t == 1) req = 1'b0;
      end
      check("rmid_guide1_before", 32'(guide1), 32'd2);
      #1 rst = 1'b1;
      #1;
      check("rmid_guide1", 32'(guide1), 32'd0);
      check("rmid_guide2", 32'(guide2), 32'd0);
      check("rmid_busy", 32'(busy), 32'd0);
      check("rmid_value", 32'(value), 32'd0);
      check("rmid_zero", 32'(zero), 32'd1);
      check("rmid_ovf", 32'(ovf), 32'd0);
      model_value = 0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_value", 32'(value), 32'd0);
      check("rst_zero", 32'(zero), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_guides", 32'(guide1 | guide2), 32'd0);
      check("rst_cath", 32'(cath_rst), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_step(1'b0);
      for (int i = 0; i < 8; i++) run_step(1'b0);
      run_step(1'b0);
      for (int i = 0; i < 6; i++) run_step(1'($urandom_range(0, 1)));

      run_clr(1'b0);
      run_step(1'b1);
      run_step(1'b0);
      run_step(1'b0);

      run_b2b();
      run_clr(1'b1);

      run_reset_mid();
      run_step(1'b0);

      repeat (3) @(negedge clk);
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
